mdu: RTL

Iterative multiply/divide unit implementing the RV64M and RV64M-W operations, placed in the EX stage alongside the ALU. It drives the stall that freezes the front-end pipeline registers while a multi-cycle operation is in flight, and accepts the flush that squashes EX contents. When the operation finishes, it presents the result for one cycle so the EX/MEM register can capture it as the ALU output.

---
 rtl/mdu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// mdu: iterative RV64M / RV64M-W multiply-divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is applied once, in the last iteration, while the
// result register is loaded.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for an M op; the start cycle latches the operands
// ST_MUL  | shift-add iterations, cnt_q counts down to 1
// ST_DIV  | restoring-divide iterations, cnt_q counts down to 1
// ST_DONE | result_o valid and done_o high for this one cycle
module mdu (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [2:0]  funct3_i,
    input  logic        word_i,
    input  logic [63:0] srcA_i,
    input  logic [63:0] srcB_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t state, state_n;

    // latched operation
    logic [2:0]   op_q;
    logic         word_q;
    logic         neg_q;
    logic [6:0]   cnt_q;

    // multiply datapath: 128-bit accumulator, multiplicand shifts left
    logic [127:0] acc_q;
    logic [127:0] mcd_q;
    logic [63:0]  mlr_q;

    // divide datapath: dividend shifts out of quo_q as quotient bits shift in
    logic [63:0]  quo_q;
    logic [63:0]  rem_q;
    logic [63:0]  dvs_q;

    logic         a_signed, b_signed, a_neg, b_neg;
    logic [63:0]  a_ext, b_ext, a_mag, b_mag, min_neg;
    logic         is_div, div_zero, div_ovf, special, start, last_iter;
    logic [63:0]  special_raw, special_res;

    logic [127:0] acc_n, mul_full;
    logic [64:0]  trial;
    logic [63:0]  quo_n, rem_n, quo_s, rem_s;
    logic [63:0]  mul_res, div_res, iter_raw, iter_res;

    assign stall_o = valid_i & ~flush_i & (state != ST_DONE);

    // operand decode, extension, magnitudes and the zero-cycle special cases
    always_comb begin
        a_signed = funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        b_signed = funct3_i inside {3'd0, 3'd1, 3'd4, 3'd6};
        a_ext    = word_i ? {{32{a_signed & srcA_i[31]}}, srcA_i[31:0]} : srcA_i;
        b_ext    = word_i ? {{32{b_signed & srcB_i[31]}}, srcB_i[31:0]} : srcB_i;
        a_neg    = a_signed & a_ext[63];
        b_neg    = b_signed & b_ext[63];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;

        is_div   = funct3_i[2];
        div_zero = (b_ext == 64'd0);
        min_neg  = word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_ovf  = is_div & ~funct3_i[0] & (a_ext == min_neg) & (b_ext == 64'hFFFF_FFFF_FFFF_FFFF);
        special  = is_div & (div_zero | div_ovf);

        // divide by zero: q = all ones, r = dividend; overflow: q = dividend, r = 0
        if (div_zero) begin
            special_raw = funct3_i[1] ? a_ext : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            special_raw = funct3_i[1] ? 64'd0 : a_ext;
        end
        special_res = word_i ? {{32{special_raw[31]}}, special_raw[31:0]} : special_raw;

        start     = (state == ST_IDLE) & valid_i & ~flush_i;
        last_iter = (cnt_q == 7'd1);
    end

    // one iteration step for each datapath and the signed, width-adjusted result
    always_comb begin
        acc_n    = mlr_q[0] ? (acc_q + mcd_q) : acc_q;
        mul_full = neg_q ? -acc_n : acc_n;
        mul_res  = (op_q[1:0] == 2'd0) ? mul_full[63:0] : mul_full[127:64];

        // a borrow out of bit 64 means the trial subtraction does not fit
        trial    = {rem_q, quo_q[63]} - {1'b0, dvs_q};
        rem_n    = trial[64] ? {rem_q[62:0], quo_q[63]} : trial[63:0];
        quo_n    = {quo_q[62:0], ~trial[64]};
        quo_s    = neg_q ? -quo_n : quo_n;
        rem_s    = neg_q ? -rem_n : rem_n;
        div_res  = op_q[1] ? rem_s : quo_s;

        iter_raw = (state == ST_DIV) ? div_res : mul_res;
        iter_res = word_q ? {{32{iter_raw[31]}}, iter_raw[31:0]} : iter_raw;
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state; flush wins over everything, including a start
    always_comb begin
        state_n = state;
        if (flush_i) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (special) begin
                            state_n = ST_DONE;
                        end else if (is_div) begin
                            state_n = ST_DIV;
                        end else begin
                            state_n = ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_iter) begin
                        state_n = ST_DONE;
                    end
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // operand latching, iteration registers and the registered result
    always_ff @(posedge clock) begin
        if (reset) begin
            done_o   <= 1'b0;
            result_o <= 64'd0;
            op_q     <= 3'd0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= 7'd0;
            acc_q    <= 128'd0;
            mcd_q    <= 128'd0;
            mlr_q    <= 64'd0;
            quo_q    <= 64'd0;
            rem_q    <= 64'd0;
            dvs_q    <= 64'd0;
        end else begin
            done_o <= (state_n == ST_DONE);
            if (start) begin
                op_q   <= funct3_i;
                word_q <= word_i;
                // remainder follows the dividend; everything else the product of signs
                neg_q  <= (funct3_i == 3'd6) ? a_neg : (a_neg ^ b_neg);
                cnt_q  <= word_i ? 7'd32 : 7'd64;
                acc_q  <= 128'd0;
                mcd_q  <= {64'd0, b_mag};
                mlr_q  <= a_mag;
                // W dividends sit in the top half so the quotient lands in bits 31:0
                quo_q  <= word_i ? {a_mag[31:0], 32'd0} : a_mag;
                rem_q  <= 64'd0;
                dvs_q  <= b_mag;
                if (special) begin
                    result_o <= special_res;
                end
            end else if (!flush_i && (state == ST_MUL || state == ST_DIV)) begin
                cnt_q <= cnt_q - 7'd1;
                acc_q <= acc_n;
                mcd_q <= mcd_q << 1;
                mlr_q <= mlr_q >> 1;
                quo_q <= quo_n;
                rem_q <= rem_n;
                if (last_iter) begin
                    result_o <= iter_res;
                end
            end
        end
    end

endmodule
